multi_cycle_control_fsm: RTL and testbench
==========================================

# multi_cycle_control_fsm

Sequencing controller for the multi-cycle MIPS-subset CPU. It splits every instruction into the IF/ID/EXE/MEM/WB phases and drives the shared datapath strobes phase by phase: PC, IR, register file, ALU muxes and data memory. It replaces the purely combinational decoder of the single-cycle core, sits between the instruction register and the datapath, and owns the only state machine in the core.

## Interface
- No parameters. Opcode, funct, ALUOp and state encodings come from the shared package.
- CLK  in  1  core clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high; forces state to IF on the next edge
- OP  in  6  opcode from IR (valid from ID onward)
- func  in  6  funct field from IR
- zero  in  1  ALU zero flag, valid in EXE
- sign  in  1  ALU result sign, valid in EXE
- state  out  4  current state, for debug and testbench
- PCWre  out  1  PC load enable
- IRWre  out  1  IR load enable
- InsMemRW  out  1  instruction memory read; constant 1
- ALUSrcA  out  1  1 = shamt to ALU A (sll)
- ALUSrcB  out  1  1 = extended immediate to ALU B
- ALUOp  out  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 110 slt-imm, 111 slt
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend (andi, ori)
- mRD  out  1  data memory read
- mWR  out  1  data memory write
- DBDataSrc  out  1  1 = write-back from data memory
- RegWre  out  1  register file write enable
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd
- WrRegDSrc  out  1  0 = PC+4 (jal), 1 = DB
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = jr (rs), 11 = jump target

## Operation
- States: IF, ID, EXE_AL, EXE_BR, EXE_LS, MEM, WB_AL, WB_LD, HALT.
- IF: IRWre = 1; next state ID.
- ID: decode.
  - j and jal finish here: PCWre = 1, PCSrc = 11. For jal also RegWre = 1, RegDst = 00, WrRegDSrc = 0. Next state IF.
  - jr finishes here: PCWre = 1, PCSrc = 10. Next state IF.
  - halt: next state HALT.
  - beq, bne, bltz: next state EXE_BR.
  - lw, sw: next state EXE_LS.
  - All other opcodes: next state EXE_AL.
- EXE_AL: ALUOp, ALUSrcA and ALUSrcB per instruction. Next state WB_AL.
- WB_AL: RegWre = 1; RegDst = 10 for R-type, 01 otherwise; WrRegDSrc = 1. PCWre = 1, PCSrc = 00. Next state IF.
- EXE_BR: ALUOp = 001 (sub), ALUSrcB = 0. PCWre = 1. PCSrc = 01 when the branch is taken, else 00:
  - beq: taken when zero = 1
  - bne: taken when zero = 0
  - bltz: taken when sign = 1
  - Next state IF.
- EXE_LS: ALUOp = 000, ALUSrcB = 1, ExtSel = 1. Next state MEM.
- MEM:
  - sw: mWR = 1, PCWre = 1, next state IF.
  - lw: mRD = 1, next state WB_LD.
- WB_LD: mRD = 1, DBDataSrc = 1, RegWre = 1, RegDst = 01, WrRegDSrc = 1, PCWre = 1. Next state IF.
- HALT: absorbing state; every strobe is 0. Only Reset leaves it.
- Default value of every strobe in every state is 0, except InsMemRW = 1.
- Unknown R-type funct or unknown opcode: executes as a NOP. Flow is IF → ID → EXE_AL → WB_AL with RegWre forced to 0 and PCWre = 1.

## Timing
- Outputs are combinational from the registered state plus OP, func, zero and sign. There are no output registers.
- Cycles per instruction, IF to the next IF:
  - j, jal, jr: 2
  - branches: 3
  - ALU ops and sw: 4
  - lw: 5
- PCWre is high in exactly one cycle per instruction, the last one. IRWre is high only in IF.
- RegWre and mWR are never high in the same cycle.
- Reset:
  - While Reset = 1, the strobes PCWre, IRWre, RegWre and mWR are forced to 0 regardless of state.
  - On the first edge with Reset = 1, state becomes 4'd0 (IF).
  - Reset mid-instruction aborts it with no register or memory write.
  - The first IF is the cycle after Reset deasserts.

## Configuration
- MC_CTRL_JAL_JR_EN defined: jal and jr are decoded as described in Operation.
- MC_CTRL_JAL_JR_EN undefined:
  - jal and jr decode as unknown and execute as NOPs (4 cycles).
  - RegDst = 00 and PCSrc = 10 are never produced.
  - WrRegDSrc is tied to 1.

## Structure
- The shared package `mc_cpu_pkg` holds:
  - opcode and funct localparams
  - state encodings (IF = 4'd0 … HALT = 4'd8)
  - ALUOp, RegDst and PCSrc encodings
- One sub-module, `mc_decode`: purely combinational; maps OP and func to instruction class and ALUOp. The FSM file holds the state register, next-state logic and strobe logic.

## Test plan
- Reset then `addu $3,$1,$2` → states IF, ID, EXE_AL, WB_AL; RegWre = 1 and RegDst = 10 only in WB_AL; PCWre = 1 only in WB_AL.
- `lw` → 5 cycles; mRD = 1 in MEM and WB_LD; DBDataSrc = 1 and RegWre = 1 in WB_LD. `sw` → mWR = 1 in MEM only, 4 cycles.
- `beq` with zero = 1 → PCSrc = 01 in EXE_BR. `bne` with zero = 1 → PCSrc = 00. `bltz` with sign = 1 → PCSrc = 01.
- `jal` with macro defined → 2 cycles; in ID, PCSrc = 11, RegWre = 1, RegDst = 00, WrRegDSrc = 0. Macro undefined → 4-cycle NOP, RegWre never high.
- `halt` → HALT reached after ID; hold 20 cycles with PCWre = RegWre = 0; Reset → IF.
- Reset asserted in MEM of `sw` → mWR = 0 that cycle; state = IF next edge.

Source files
------------

// File: rtl/mc_cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : mc_cpu_pkg                                                     |
// | Purpose   : Shared encodings for the multi-cycle MIPS-subset core:         |
// |             opcodes, funct codes, FSM state codes, ALUOp / RegDst / PCSrc  |
// |             encodings and the decoded-instruction record.                  |
// | Macros    : MC_CTRL_JAL_JR_EN (consumed by mc_decode and the FSM)          |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package mc_cpu_pkg;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BLTZ  = 6'b000001;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   // R-type funct codes
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   // FSM state encodings
   localparam logic [3:0] S_IF     = 4'd0;
   localparam logic [3:0] S_ID     = 4'd1;
   localparam logic [3:0] S_EXE_AL = 4'd2;
   localparam logic [3:0] S_EXE_BR = 4'd3;
   localparam logic [3:0] S_EXE_LS = 4'd4;
   localparam logic [3:0] S_MEM    = 4'd5;
   localparam logic [3:0] S_WB_AL  = 4'd6;
   localparam logic [3:0] S_WB_LD  = 4'd7;
   localparam logic [3:0] S_HALT   = 4'd8;

   // ALUOp encodings
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_SLL  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_AND  = 3'b100;
   localparam logic [2:0] ALU_SLTI = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   // RegDst encodings
   localparam logic [1:0] REGDST_RA = 2'b00;
   localparam logic [1:0] REGDST_RT = 2'b01;
   localparam logic [1:0] REGDST_RD = 2'b10;

   // PCSrc encodings
   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JR  = 2'b10;
   localparam logic [1:0] PCSRC_JMP = 2'b11;

   // Instruction classes seen by the sequencer
   typedef enum logic [3:0] {
      CLS_NOP  = 4'd0,
      CLS_ALU  = 4'd1,
      CLS_BEQ  = 4'd2,
      CLS_BNE  = 4'd3,
      CLS_BLTZ = 4'd4,
      CLS_LW   = 4'd5,
      CLS_SW   = 4'd6,
      CLS_J    = 4'd7,
      CLS_JAL  = 4'd8,
      CLS_JR   = 4'd9,
      CLS_HALT = 4'd10
   } instr_cls_e;

   typedef struct packed {
      instr_cls_e cls;
      logic [2:0] alu_op;
      logic       alu_src_a;
      logic       alu_src_b;
      logic       ext_sel;
   } dec_t;

endpackage : mc_cpu_pkg
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : mc_decode                                                      |
// | Purpose   : Combinational instruction decoder. Maps opcode/funct to an     |
// |             instruction class plus the EXE-phase ALU controls.             |
// | Ports     : op_i   [5:0] opcode from IR                                    |
// |             func_i [5:0] funct field from IR                               |
// |             dec_o        decoded record (class, ALUOp, srcA, srcB, ext)    |
// | Macros    : MC_CTRL_JAL_JR_EN - when undefined jal/jr decode as NOP        |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module mc_decode
   import mc_cpu_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] func_i,
   output dec_t       dec_o
);

   always_comb begin
      dec_o           = '0;
      dec_o.cls       = CLS_NOP;
      dec_o.alu_op    = ALU_ADD;
      case (op_i)
         OP_RTYPE: begin
            case (func_i)
               FN_ADDU: begin dec_o.cls = CLS_ALU; dec_o.alu_op = ALU_ADD; end
               FN_SUBU: begin dec_o.cls = CLS_ALU; dec_o.alu_op = ALU_SUB; end
               FN_SLL: begin
                  dec_o.cls       = CLS_ALU;
                  dec_o.alu_op    = ALU_SLL;
                  dec_o.alu_src_a = 1'b1;   // shamt feeds ALU A
               end
               FN_OR:   begin dec_o.cls = CLS_ALU; dec_o.alu_op = ALU_OR;  end
               FN_AND:  begin dec_o.cls = CLS_ALU; dec_o.alu_op = ALU_AND; end
               FN_SLT:  begin dec_o.cls = CLS_ALU; dec_o.alu_op = ALU_SLT; end
`ifdef MC_CTRL_JAL_JR_EN
               FN_JR:   dec_o.cls = CLS_JR;
`endif
               default: dec_o.cls = CLS_NOP;
            endcase
         end
         OP_ADDIU: begin
            dec_o.cls = CLS_ALU; dec_o.alu_op = ALU_ADD;
            dec_o.alu_src_b = 1'b1; dec_o.ext_sel = 1'b1;
         end
         OP_SLTI: begin
            dec_o.cls = CLS_ALU; dec_o.alu_op = ALU_SLTI;
            dec_o.alu_src_b = 1'b1; dec_o.ext_sel = 1'b1;
         end
         // Logical immediates are zero-extended
         OP_ANDI: begin
            dec_o.cls = CLS_ALU; dec_o.alu_op = ALU_AND; dec_o.alu_src_b = 1'b1;
         end
         OP_ORI: begin
            dec_o.cls = CLS_ALU; dec_o.alu_op = ALU_OR; dec_o.alu_src_b = 1'b1;
         end
         OP_BEQ:  begin dec_o.cls = CLS_BEQ;  dec_o.alu_op = ALU_SUB; end
         OP_BNE:  begin dec_o.cls = CLS_BNE;  dec_o.alu_op = ALU_SUB; end
         OP_BLTZ: begin dec_o.cls = CLS_BLTZ; dec_o.alu_op = ALU_SUB; end
         OP_LW: begin
            dec_o.cls = CLS_LW; dec_o.alu_src_b = 1'b1; dec_o.ext_sel = 1'b1;
         end
         OP_SW: begin
            dec_o.cls = CLS_SW; dec_o.alu_src_b = 1'b1; dec_o.ext_sel = 1'b1;
         end
         OP_J:    dec_o.cls = CLS_J;
`ifdef MC_CTRL_JAL_JR_EN
         OP_JAL:  dec_o.cls = CLS_JAL;
`endif
         OP_HALT: dec_o.cls = CLS_HALT;
         default: dec_o.cls = CLS_NOP;
      endcase
   end

endmodule : mc_decode
`default_nettype wire

// File: rtl/multi_cycle_control_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : multi_cycle_control_fsm                                        |
// | Purpose   : Phase sequencer (IF/ID/EXE/MEM/WB) for the multi-cycle         |
// |             MIPS-subset core. Strobes are combinational from the state     |
// |             register plus OP/func/zero/sign.                               |
// | Ports     : CLK, Reset (sync, active-high), OP, func, zero, sign in;       |
// |             state, PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp,        |
// |             ExtSel, mRD, mWR, DBDataSrc, RegWre, RegDst, WrRegDSrc,        |
// |             PCSrc out.                                                     |
// | Macros    : MC_CTRL_JAL_JR_EN - enables jal/jr; otherwise they run as NOPs |
// |             and WrRegDSrc is held at 1.                                    |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module multi_cycle_control_fsm
   import mc_cpu_pkg::*;
(
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] OP,
   input  logic [5:0] func,
   input  logic       zero,
   input  logic       sign,
   output logic [3:0] state,
   output logic       PCWre,
   output logic       IRWre,
   output logic       InsMemRW,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       ExtSel,
   output logic       mRD,
   output logic       mWR,
   output logic       DBDataSrc,
   output logic       RegWre,
   output logic [1:0] RegDst,
   output logic       WrRegDSrc,
   output logic [1:0] PCSrc
);

`ifdef MC_CTRL_JAL_JR_EN
   localparam logic WRSRC_DEFAULT = 1'b0;
`else
   // Without jal there is no PC+4 write-back path to select
   localparam logic WRSRC_DEFAULT = 1'b1;
`endif

   logic [3:0] state_q;
   logic [3:0] state_d;
   dec_t       dec;

   mc_decode u_decode (
      .op_i   (OP),
      .func_i (func),
      .dec_o  (dec)
   );

   assign state    = state_q;
   assign InsMemRW = 1'b1;

   // State register
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= S_IF;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = S_IF;
      case (state_q)
         S_IF: state_d = S_ID;
         S_ID: begin
            case (dec.cls)
               CLS_J:                      state_d = S_IF;
`ifdef MC_CTRL_JAL_JR_EN
               CLS_JAL, CLS_JR:            state_d = S_IF;
`endif
               CLS_HALT:                   state_d = S_HALT;
               CLS_BEQ, CLS_BNE, CLS_BLTZ: state_d = S_EXE_BR;
               CLS_LW, CLS_SW:             state_d = S_EXE_LS;
               default:                    state_d = S_EXE_AL;
            endcase
         end
         S_EXE_AL: state_d = S_WB_AL;
         S_WB_AL:  state_d = S_IF;
         S_EXE_BR: state_d = S_IF;
         S_EXE_LS: state_d = S_MEM;
         S_MEM:    state_d = (dec.cls == CLS_LW) ? S_WB_LD : S_IF;
         S_WB_LD:  state_d = S_IF;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IF;
      endcase
   end

   // Strobe logic
   always_comb begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = ALU_ADD;
      ExtSel    = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      DBDataSrc = 1'b0;
      RegWre    = 1'b0;
      RegDst    = REGDST_RA;
      WrRegDSrc = WRSRC_DEFAULT;
      PCSrc     = PCSRC_SEQ;
      case (state_q)
         S_IF: IRWre = 1'b1;
         S_ID: begin
            case (dec.cls)
               CLS_J: begin
                  PCWre = 1'b1;
                  PCSrc = PCSRC_JMP;
               end
`ifdef MC_CTRL_JAL_JR_EN
               CLS_JAL: begin
                  PCWre     = 1'b1;
                  PCSrc     = PCSRC_JMP;
                  RegWre    = 1'b1;
                  RegDst    = REGDST_RA;
                  WrRegDSrc = 1'b0;
               end
               CLS_JR: begin
                  PCWre = 1'b1;
                  PCSrc = PCSRC_JR;
               end
`endif
               default: ;
            endcase
         end
         S_EXE_AL: begin
            ALUOp   = dec.alu_op;
            ALUSrcA = dec.alu_src_a;
            ALUSrcB = dec.alu_src_b;
            ExtSel  = dec.ext_sel;
         end
         S_WB_AL: begin
            // Unknown instructions reach here as NOPs: no register write
            RegWre    = (dec.cls == CLS_ALU);
            RegDst    = (OP == OP_RTYPE) ? REGDST_RD : REGDST_RT;
            WrRegDSrc = 1'b1;
            PCWre     = 1'b1;
            PCSrc     = PCSRC_SEQ;
         end
         S_EXE_BR: begin
            ALUOp = ALU_SUB;
            PCWre = 1'b1;
            case (dec.cls)
               CLS_BEQ:  PCSrc = zero  ? PCSRC_BR : PCSRC_SEQ;
               CLS_BNE:  PCSrc = !zero ? PCSRC_BR : PCSRC_SEQ;
               CLS_BLTZ: PCSrc = sign  ? PCSRC_BR : PCSRC_SEQ;
               default:  PCSrc = PCSRC_SEQ;
            endcase
         end
         S_EXE_LS: begin
            ALUOp   = ALU_ADD;
            ALUSrcB = 1'b1;
            ExtSel  = 1'b1;
         end
         S_MEM: begin
            if (dec.cls == CLS_LW) begin
               mRD = 1'b1;
            end else begin
               mWR   = 1'b1;
               PCWre = 1'b1;
            end
         end
         S_WB_LD: begin
            mRD       = 1'b1;
            DBDataSrc = 1'b1;
            RegWre    = 1'b1;
            RegDst    = REGDST_RT;
            WrRegDSrc = 1'b1;
            PCWre     = 1'b1;
         end
         default: ;  // HALT and unused codes: everything idle
      endcase

      // Reset aborts the current instruction: no architectural side effects
      if (Reset) begin
         PCWre  = 1'b0;
         IRWre  = 1'b0;
         RegWre = 1'b0;
         mWR    = 1'b0;
      end
   end

endmodule : multi_cycle_control_fsm
`default_nettype wire

// File: tb/tb_multi_cycle_control_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_multi_cycle_control_fsm                                     |
// | Purpose   : Scoreboard bench for multi_cycle_control_fsm. Directed         |
// |             instruction sequences push per-cycle expected strobe vectors;  |
// |             a monitor pops and compares them on the falling edge.          |
// | Macros    : MC_CTRL_JAL_JR_EN selects jal/jr expectations                  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_multi_cycle_control_fsm;

   typedef struct packed {
      logic [3:0] st;
      logic       pcwre;
      logic       irwre;
      logic       imrw;
      logic       srca;
      logic       srcb;
      logic [2:0] aluop;
      logic       ext;
      logic       mrd;
      logic       mwr;
      logic       dbsrc;
      logic       regwre;
      logic [1:0] regdst;
      logic       wrsrc;
      logic [1:0] pcsrc;
   } vec_t;

`ifdef MC_CTRL_JAL_JR_EN
   localparam logic WDEF = 1'b0;
`else
   localparam logic WDEF = 1'b1;
`endif

   logic       CLK;
   logic       Reset;
   logic [5:0] OP;
   logic [5:0] func;
   logic       zero;
   logic       sign;
   logic [3:0] state;
   logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel;
   logic       mRD, mWR, DBDataSrc, RegWre, WrRegDSrc;
   logic [2:0] ALUOp;
   logic [1:0] RegDst, PCSrc;

   int checks = 0;
   int errors = 0;

   string q_name[$];
   vec_t  q_exp[$];

   multi_cycle_control_fsm dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .OP        (OP),
      .func      (func),
      .zero      (zero),
      .sign      (sign),
      .state     (state),
      .PCWre     (PCWre),
      .IRWre     (IRWre),
      .InsMemRW  (InsMemRW),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .ExtSel    (ExtSel),
      .mRD       (mRD),
      .mWR       (mWR),
      .DBDataSrc (DBDataSrc),
      .RegWre    (RegWre),
      .RegDst    (RegDst),
      .WrRegDSrc (WrRegDSrc),
      .PCSrc     (PCSrc)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Baseline vector for a state: only InsMemRW and the WrRegDSrc default
   function automatic vec_t b(input logic [3:0] st);
      vec_t v;
      v       = '0;
      v.st    = st;
      v.imrw  = 1'b1;
      v.wrsrc = WDEF;
      return v;
   endfunction

   function automatic vec_t f_if();
      vec_t v;
      v       = b(4'd0);
      v.irwre = 1'b1;
      return v;
   endfunction

   // One clock of stimulus plus its expected response
   task automatic cyc(input string nm, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic s, input logic rst, input vec_t e);
      @(posedge CLK);
      #1;
      OP    = op;
      func  = fn;
      zero  = z;
      sign  = s;
      Reset = rst;
      q_name.push_back(nm);
      q_exp.push_back(e);
   endtask

   task automatic run_alu(input string nm, input logic [5:0] op, input logic [5:0] fn,
                          input logic [2:0] aop, input logic sa, input logic sb,
                          input logic ex, input logic we, input logic [1:0] rd);
      vec_t v;
      cyc({nm, ".if"}, op, fn, 1'b0, 1'b0, 1'b0, f_if());
      cyc({nm, ".id"}, op, fn, 1'b0, 1'b0, 1'b0, b(4'd1));
      v = b(4'd2); v.aluop = aop; v.srca = sa; v.srcb = sb; v.ext = ex;
      cyc({nm, ".exe"}, op, fn, 1'b0, 1'b0, 1'b0, v);
      v = b(4'd6); v.regwre = we; v.regdst = rd; v.wrsrc = 1'b1; v.pcwre = 1'b1;
      cyc({nm, ".wb"}, op, fn, 1'b0, 1'b0, 1'b0, v);
   endtask

   task automatic run_br(input string nm, input logic [5:0] op, input logic z,
                         input logic s, input logic [1:0] pcs);
      vec_t v;
      cyc({nm, ".if"}, op, 6'd0, z, s, 1'b0, f_if());
      cyc({nm, ".id"}, op, 6'd0, z, s, 1'b0, b(4'd1));
      v = b(4'd3); v.aluop = 3'b001; v.pcwre = 1'b1; v.pcsrc = pcs;
      cyc({nm, ".exe"}, op, 6'd0, z, s, 1'b0, v);
   endtask

   task automatic run_ls_front(input string nm, input logic [5:0] op);
      vec_t v;
      cyc({nm, ".if"}, op, 6'd0, 1'b0, 1'b0, 1'b0, f_if());
      cyc({nm, ".id"}, op, 6'd0, 1'b0, 1'b0, 1'b0, b(4'd1));
      v = b(4'd4); v.srcb = 1'b1; v.ext = 1'b1;
      cyc({nm, ".exe"}, op, 6'd0, 1'b0, 1'b0, 1'b0, v);
   endtask

   // Monitor: one expected vector per cycle, sampled mid-cycle
   initial begin
      vec_t  a;
      vec_t  e;
      string nm;
      forever begin
         @(negedge CLK);
         if (q_exp.size() > 0) begin
            nm = q_name.pop_front();
            e  = q_exp.pop_front();
            a.st = state;      a.pcwre = PCWre;   a.irwre = IRWre;
            a.imrw = InsMemRW; a.srca = ALUSrcA;  a.srcb = ALUSrcB;
            a.aluop = ALUOp;   a.ext = ExtSel;    a.mrd = mRD;
            a.mwr = mWR;       a.dbsrc = DBDataSrc; a.regwre = RegWre;
            a.regdst = RegDst; a.wrsrc = WrRegDSrc; a.pcsrc = PCSrc;
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL %s actual=%h required=%h", nm, a, e);
            end
         end
      end
   end

   initial begin
      vec_t v;
      Reset = 1'b1; OP = 6'd0; func = 6'd0; zero = 1'b0; sign = 1'b0;

      // Reset: state IF, IRWre masked while Reset is high
      cyc("reset0", 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, b(4'd0));
      cyc("reset1", 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, b(4'd0));

      // ALU ops:            op         funct      aluop   sa    sb    ex   we    rd
      run_alu("addu", 6'b000000, 6'b100001, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
      run_alu("sll",  6'b000000, 6'b000000, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10);
      run_alu("ori",  6'b001101, 6'b000000, 3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
      run_alu("slti", 6'b001010, 6'b000000, 3'b110, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01);
      run_alu("badop", 6'b010000, 6'b000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
      run_alu("badfn", 6'b000000, 6'b111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);

      // lw: 5 cycles
      run_ls_front("lw", 6'b100011);
      v = b(4'd5); v.mrd = 1'b1;
      cyc("lw.mem", 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, v);
      v = b(4'd7); v.mrd = 1'b1; v.dbsrc = 1'b1; v.regwre = 1'b1;
      v.regdst = 2'b01; v.wrsrc = 1'b1; v.pcwre = 1'b1;
      cyc("lw.wb", 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, v);

      // sw: 4 cycles
      run_ls_front("sw", 6'b101011);
      v = b(4'd5); v.mwr = 1'b1; v.pcwre = 1'b1;
      cyc("sw.mem", 6'b101011, 6'd0, 1'b0, 1'b0, 1'b0, v);

      // Branches
      run_br("beq_t",  6'b000100, 1'b1, 1'b0, 2'b01);
      run_br("beq_n",  6'b000100, 1'b0, 1'b0, 2'b00);
      run_br("bne_n",  6'b000101, 1'b1, 1'b0, 2'b00);
      run_br("bne_t",  6'b000101, 1'b0, 1'b0, 2'b01);
      run_br("bltz_t", 6'b000001, 1'b0, 1'b1, 2'b01);
      run_br("bltz_n", 6'b000001, 1'b1, 1'b0, 2'b00);

      // j: 2 cycles
      cyc("j.if", 6'b000010, 6'd0, 1'b0, 1'b0, 1'b0, f_if());
      v = b(4'd1); v.pcwre = 1'b1; v.pcsrc = 2'b11;
      cyc("j.id", 6'b000010, 6'd0, 1'b0, 1'b0, 1'b0, v);

`ifdef MC_CTRL_JAL_JR_EN
      cyc("jal.if", 6'b000011, 6'd0, 1'b0, 1'b0, 1'b0, f_if());
      v = b(4'd1); v.pcwre = 1'b1; v.pcsrc = 2'b11; v.regwre = 1'b1;
      v.regdst = 2'b00; v.wrsrc = 1'b0;
      cyc("jal.id", 6'b000011, 6'd0, 1'b0, 1'b0, 1'b0, v);
      cyc("jr.if", 6'b000000, 6'b001000, 1'b0, 1'b0, 1'b0, f_if());
      v = b(4'd1); v.pcwre = 1'b1; v.pcsrc = 2'b10;
      cyc("jr.id", 6'b000000, 6'b001000, 1'b0, 1'b0, 1'b0, v);
`else
      run_alu("jal_nop", 6'b000011, 6'b000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
      run_alu("jr_nop",  6'b000000, 6'b001000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
`endif

      // halt: absorbing until Reset
      cyc("halt.if", 6'b111111, 6'd0, 1'b0, 1'b0, 1'b0, f_if());
      cyc("halt.id", 6'b111111, 6'd0, 1'b0, 1'b0, 1'b0, b(4'd1));
      for (int i = 0; i < 20; i++) begin
         cyc("halt.hold", 6'b111111, 6'd0, 1'b1, 1'b1, 1'b0, b(4'd8));
      end
      cyc("halt.rst", 6'b111111, 6'd0, 1'b0, 1'b0, 1'b1, b(4'd8));
      cyc("halt.exit", 6'b000000, 6'b100001, 1'b0, 1'b0, 1'b0, f_if());
      cyc("post.id", 6'b000000, 6'b100001, 1'b0, 1'b0, 1'b0, b(4'd1));
      cyc("post.exe", 6'b000000, 6'b100001, 1'b0, 1'b0, 1'b0, b(4'd2));
      v = b(4'd6); v.regwre = 1'b1; v.regdst = 2'b10; v.wrsrc = 1'b1; v.pcwre = 1'b1;
      cyc("post.wb", 6'b000000, 6'b100001, 1'b0, 1'b0, 1'b0, v);

      // Reset during sw MEM: write suppressed, back to IF
      run_ls_front("swr", 6'b101011);
      cyc("swr.mem", 6'b101011, 6'd0, 1'b0, 1'b0, 1'b1, b(4'd5));
      cyc("swr.if", 6'b101011, 6'd0, 1'b0, 1'b0, 1'b0, f_if());
      cyc("swr.id", 6'b101011, 6'd0, 1'b0, 1'b0, 1'b0, b(4'd1));

      // Let the monitor drain, bounded
      for (int i = 0; i < 10 && q_exp.size() > 0; i++) begin
         @(posedge CLK);
      end
      if (q_exp.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain actual=%0d required=0", q_exp.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_multi_cycle_control_fsm
`default_nettype wire
